// File: rtl/fc_tcdm_mux_pkg.sv
// rtl/fc_tcdm_mux_pkg.sv - shared types and constants for the two-initiator TCDM mux
package fc_tcdm_mux_pkg;

  // Initiator identifier: one bit selects port 0 or port 1
  typedef logic init_id_t;

  localparam int unsigned NUM_PORTS               = 2;
  localparam int unsigned DEF_ADDR_WIDTH          = 32;
  localparam int unsigned DEF_DATA_WIDTH          = 32;
  localparam int unsigned DEF_MAX_OUTSTANDING     = 2;

  // One-hot port vector for an initiator ID
  function automatic logic [NUM_PORTS-1:0] id_onehot(input init_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/fc_route_fifo.sv
// rtl/fc_route_fifo.sv - in-order FIFO of initiator IDs for response routing
module fc_route_fifo
  import fc_tcdm_mux_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MAX_OUTSTANDING
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  init_id_t din,
  output init_id_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  init_id_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push_ok;
  logic               pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Route storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fc_tcdm_mux.sv
// rtl/fc_tcdm_mux.sv - round-robin merge of two TCDM initiators onto one target
module fc_tcdm_mux
  import fc_tcdm_mux_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_PORTS-1:0]                    s_req_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]    s_add_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    s_wdata_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]  s_be_i,
  input  logic [NUM_PORTS-1:0]                    s_wen_i,
  output logic [NUM_PORTS-1:0]                    s_gnt_o,
  output logic [NUM_PORTS-1:0]                    s_r_valid_o,
  output logic [DATA_WIDTH-1:0]                   s_r_rdata_o,
  output logic                                    m_req_o,
  output logic [ADDR_WIDTH-1:0]                   m_add_o,
  output logic [DATA_WIDTH-1:0]                   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                 m_be_o,
  output logic                                    m_wen_o,
  input  logic                                    m_gnt_i,
  input  logic                                    m_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                   m_r_rdata_i,
  output logic                                    err_o
);

  init_id_t rr_q;
  init_id_t winner;
  init_id_t head;
  logic     any_req;
  logic     full;
  logic     empty;
  logic     accept;
  logic     pop;
  logic     err_q;

  assign any_req = |s_req_i;

  // Round-robin pick: a lone requester wins, a tie goes to the port rr_q points at
  always_comb begin
    winner = rr_q;
    case (s_req_i)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = rr_q;
    endcase
  end

  // A full route FIFO blocks new requests even if a response frees a slot this cycle
  assign m_req_o = any_req & ~full;
  assign accept  = m_req_o & m_gnt_i;
  assign s_gnt_o = accept ? id_onehot(winner) : '0;

  // Winner's request fields to the target, zeroed when idle to avoid needless toggling
  always_comb begin
    m_add_o   = '0;
    m_wdata_o = '0;
    m_be_o    = '0;
    m_wen_o   = 1'b0;
    if (any_req) begin
      m_add_o   = s_add_i[winner];
      m_wdata_o = s_wdata_i[winner];
      m_be_o    = s_be_i[winner];
      m_wen_o   = s_wen_i[winner];
    end
  end

  // Responses are steered to the oldest outstanding initiator with no added latency
  assign pop         = m_r_valid_i & ~empty;
  assign s_r_valid_o = pop ? id_onehot(head) : '0;
  assign s_r_rdata_o = m_r_rdata_i;
  assign err_o       = err_q;

  fc_route_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .din   (winner),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Priority moves to the other port after every accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (accept) begin
      rr_q <= ~winner;
    end
  end

  // Sticky flag for a target response that had no outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (m_r_valid_i && empty) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_tcdm_mux.sv
// tb/tb_fc_tcdm_mux.sv - scoreboard bench for fc_tcdm_mux against a queue-based model
module tb_fc_tcdm_mux;

  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        s_req_i;
  logic [1:0][31:0]  s_add_i;
  logic [1:0][31:0]  s_wdata_i;
  logic [1:0][3:0]   s_be_i;
  logic [1:0]        s_wen_i;
  logic [1:0]        s_gnt_o;
  logic [1:0]        s_r_valid_o;
  logic [31:0]       s_r_rdata_o;
  logic              m_req_o;
  logic [31:0]       m_add_o;
  logic [31:0]       m_wdata_o;
  logic [3:0]        m_be_o;
  logic              m_wen_o;
  logic              m_gnt_i;
  logic              m_r_valid_i;
  logic [31:0]       m_r_rdata_i;
  logic              err_o;

  typedef struct {
    logic [1:0]  gnt;
    logic        mreq;
    logic [31:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wen;
    logic [1:0]  rv;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   outq[$];
  int   last_gnt;
  logic err_m;
  int   n_cmp = 0;
  int   n_bad = 0;

  fc_tcdm_mux #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_req_i     (s_req_i),
    .s_add_i     (s_add_i),
    .s_wdata_i   (s_wdata_i),
    .s_be_i      (s_be_i),
    .s_wen_i     (s_wen_i),
    .s_gnt_o     (s_gnt_o),
    .s_r_valid_o (s_r_valid_o),
    .s_r_rdata_o (s_r_rdata_o),
    .m_req_o     (m_req_o),
    .m_add_o     (m_add_o),
    .m_wdata_o   (m_wdata_o),
    .m_be_o      (m_be_o),
    .m_wen_o     (m_wen_o),
    .m_gnt_i     (m_gnt_i),
    .m_r_valid_i (m_r_valid_i),
    .m_r_rdata_i (m_r_rdata_i),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: act=%h req=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every non-reset cycle the DUT outputs are compared with the queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: act=empty req=entry at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("s_gnt_o",     32'(s_gnt_o),     32'(e.gnt));
        chk("m_req_o",     32'(m_req_o),     32'(e.mreq));
        chk("m_add_o",     m_add_o,          e.add);
        chk("m_wdata_o",   m_wdata_o,        e.wdata);
        chk("m_be_o",      32'(m_be_o),      32'(e.be));
        chk("m_wen_o",     32'(m_wen_o),     32'(e.wen));
        chk("s_r_valid_o", 32'(s_r_valid_o), 32'(e.rv));
        chk("s_r_rdata_o", s_r_rdata_o,      e.rdata);
        chk("err_o",       32'(err_o),       32'(e.err));
      end
    end
  end

  // One bus cycle: drive inputs, then predict outputs from the outstanding-route queue
  task automatic step(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
    exp_t e;
    int   w;
    bit   full;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_req_i = req;
    for (int k = 0; k < 2; k++) begin
      s_add_i[k]   = $urandom;
      s_wdata_i[k] = $urandom;
      s_be_i[k]    = 4'($urandom_range(0, 15));
      s_wen_i[k]   = 1'($urandom_range(0, 1));
    end
    m_gnt_i     = gnt;
    m_r_valid_i = rv;
    m_r_rdata_i = rdata;

    full = (outq.size() == DEPTH);
    if (req == 2'b01)      w = 0;
    else if (req == 2'b10) w = 1;
    else                   w = (last_gnt == 0) ? 1 : 0;

    e.mreq  = (req != 2'b00) && !full;
    e.gnt   = (e.mreq && gnt) ? 2'(1 << w) : 2'b00;
    e.add   = (req != 2'b00) ? s_add_i[w]   : 32'h0;
    e.wdata = (req != 2'b00) ? s_wdata_i[w] : 32'h0;
    e.be    = (req != 2'b00) ? s_be_i[w]    : 4'h0;
    e.wen   = (req != 2'b00) ? s_wen_i[w]   : 1'b0;
    e.rdata = rdata;
    e.err   = err_m;
    e.rv    = 2'b00;
    if (rv) begin
      if (outq.size() > 0) e.rv = 2'(1 << outq.pop_front());
      else                 err_m = 1'b1;
    end
    if (e.gnt != 2'b00) begin
      outq.push_back(w);
      last_gnt = w;
    end
    exp_q.push_back(e);
  endtask

  // Hold reset for two cycles with idle inputs and check the quiescent outputs
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    s_req_i     = '0;
    m_gnt_i     = 1'b0;
    m_r_valid_i = 1'b0;
    m_r_rdata_i = '0;
    outq.delete();
    last_gnt = 1;
    err_m    = 1'b0;
    @(negedge clk);
    chk("reset_m_req_o",     32'(m_req_o),     32'h0);
    chk("reset_s_gnt_o",     32'(s_gnt_o),     32'h0);
    chk("reset_s_r_valid_o", 32'(s_r_valid_o), 32'h0);
    chk("reset_err_o",       32'(err_o),       32'h0);
    @(posedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    s_req_i     = '0;
    s_add_i     = '0;
    s_wdata_i   = '0;
    s_be_i      = '0;
    s_wen_i     = '0;
    m_gnt_i     = 1'b0;
    m_r_valid_i = 1'b0;
    m_r_rdata_i = '0;
    last_gnt    = 1;
    err_m       = 1'b0;

    // Single initiator read with response one cycle later
    do_reset();
    step(2'b01, 1'b1, 1'b0, 32'h0);
    step(2'b00, 1'b0, 1'b1, 32'hCAFE0001);
    step(2'b00, 1'b0, 1'b0, 32'h0);

    // Both initiators request every cycle, responses stream one cycle behind
    do_reset();
    step(2'b11, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1, 1'b1, $urandom);
    step(2'b00, 1'b0, 1'b1, $urandom);

    // Responses withheld: third request stalls until a response frees a slot
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1, 1'b0, $urandom);
    step(2'b11, 1'b1, 1'b1, $urandom);
    step(2'b11, 1'b1, 1'b0, $urandom);
    step(2'b00, 1'b0, 1'b1, $urandom);
    step(2'b00, 1'b0, 1'b1, $urandom);

    // Target withholds grant: no push, priority does not move
    do_reset();
    step(2'b01, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0, $urandom);
    step(2'b11, 1'b1, 1'b1, $urandom);
    step(2'b11, 1'b1, 1'b1, $urandom);
    step(2'b00, 1'b0, 1'b1, $urandom);

    // Stray response sets the sticky error, which survives idle cycles
    do_reset();
    step(2'b00, 1'b0, 1'b1, $urandom);
    for (int i = 0; i < 4; i++) step(2'b10, 1'b0, 1'b0, $urandom);

    // Reset with two routes outstanding, then fresh traffic and a stale response
    do_reset();
    step(2'b11, 1'b1, 1'b0, $urandom);
    step(2'b11, 1'b1, 1'b0, $urandom);
    do_reset();
    step(2'b10, 1'b1, 1'b0, $urandom);
    step(2'b00, 1'b0, 1'b1, $urandom);
    step(2'b00, 1'b0, 1'b1, $urandom);
    step(2'b00, 1'b0, 1'b0, $urandom);

    // Randomized traffic with occasional mid-flight resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [1:0] req;
      logic       gnt;
      logic       rv;
      req = 2'($urandom_range(0, 3));
      gnt = ($urandom_range(0, 3) != 0);
      if (outq.size() > 0) rv = 1'($urandom_range(0, 1));
      else                 rv = ($urandom_range(0, 39) == 0);
      step(req, gnt, rv, $urandom);
      if (i % 150 == 149) do_reset();
    end
    step(2'b00, 1'b0, 1'b0, $urandom);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_tcdm_mux.md
FC_TCDM_MUX -- requirements
Module: fc_tcdm_mux

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; byte enable is DATA_WIDTH/8.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, route FIFO depth (power of two, >=1).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 s_req_i  in  2  per-initiator request, bit k = initiator k.
REQ-008 s_add_i, s_wdata_i, s_be_i, s_wen_i  in  2x width  per-initiator address/write data/byte enable/write-enable (1 = read).
REQ-009 s_gnt_o  out  2  per-initiator grant.
REQ-010 s_r_valid_o  out  2  per-initiator response valid.
REQ-011 s_r_rdata_o  out  DATA_WIDTH  response data, shared by both initiators.
REQ-012 m_req_o, m_add_o, m_wdata_o, m_be_o, m_wen_o  out  target-side request fields.
REQ-013 m_gnt_i  in  1  target grant; m_r_valid_i  in  1; m_r_rdata_i  in  DATA_WIDTH.
REQ-014 err_o  out  1  sticky: target response with no outstanding request.

Function
REQ-015 SHALL merge two TCDM initiators onto one target; request accepted in a cycle where req and gnt are both high.
REQ-016 Target responds in order, >=1 cycle after acceptance; block SHALL support back-to-back acceptance every cycle.
REQ-017 Arbitration SHALL be combinational round-robin: single requester wins; both requesting -> port rr_q wins.
REQ-018 On an accepted request from port k, rr_q SHALL become ~k next cycle; otherwise rr_q holds.
REQ-019 m_req_o = (s_req_i != 0) AND NOT full; m_add/wdata/be/wen SHALL be the winner's fields, zero when no request (operand isolation).
REQ-020 s_gnt_o[k] = winner==k AND m_gnt_i AND NOT full; loser's gnt SHALL be 0.
REQ-021 Each acceptance SHALL push winner ID into a route FIFO of depth MAX_OUTSTANDING.
REQ-022 full = (count == MAX_OUTSTANDING); full SHALL block acceptance even when a pop occurs in the same cycle.
REQ-023 m_r_valid_i with FIFO non-empty SHALL pop the head and assert s_r_valid_o[head] in the same cycle (zero added latency).
REQ-024 s_r_rdata_o SHALL equal m_r_rdata_i combinationally; the non-owner's r_valid SHALL be 0.
REQ-025 Simultaneous push and pop (not full) SHALL leave count unchanged, pointers advance independently, wrap modulo depth.
REQ-026 m_r_valid_i with FIFO empty SHALL be dropped (no s_r_valid_o) and set err_o, held until reset.
REQ-027 A held request (req high, gnt low) SHALL keep its fields stable; block SHALL not require it, nor re-latch fields.

Reset
REQ-028 On rst_n low: FIFO empty (count 0, pointers 0), rr_q = 0, err_o = 0; all outputs follow REQ-019/020/023 from that state.
REQ-029 Reset mid-operation SHALL discard outstanding routes; later responses set err_o per REQ-026.

Structure
REQ-030 Package fc_tcdm_mux_pkg SHALL hold the initiator-ID type (1 bit), port count constant (2) and default widths.
REQ-031 Route FIFO SHALL be a sub-module fc_route_fifo (push/pop/full/empty/head, parametric depth).
REQ-032 Arbiter and field mux SHALL be inline combinational logic in fc_tcdm_mux.

Verification
REQ-033 Only port 0 reads 0x1000, m_gnt_i=1, response 0xCAFE0001 one cycle later -> s_gnt_o=01, s_r_valid_o=01, rdata 0xCAFE0001.
REQ-034 Both request 4 consecutive cycles from reset, m_gnt_i=1, depth 4 -> grant order 0,1,0,1; responses routed 0,1,0,1.
REQ-035 Depth 2, responses withheld, 3 back-to-back requests -> third stalls (m_req_o=0, gnt 0) until first response; accepted in cycle after.
REQ-036 m_gnt_i=0 for 3 cycles with both requesting -> no push, rr_q unchanged, winner stays port rr_q.
REQ-037 m_r_valid_i pulse with empty FIFO -> no s_r_valid_o, err_o=1 stays until rst_n low.
REQ-038 rst_n asserted with 2 outstanding -> count 0, rr_q 0, err_o 0; next accepted request routes correctly.
